// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Request/response bundle between the EX/MEM pipeline register and the
// load/store unit.
//
// Handshake: a request transfers on the rising clk edge where req_valid and
// req_ready are both 1. The master holds req_* stable while req_valid=1 and
// req_ready=0. The LSU samples req_* only on that edge and ignores them at
// every other time. resp_valid is a single-cycle pulse with no back-pressure;
// resp_err and resp_rdata are meaningful in that cycle, and resp_rdata keeps
// its value until the next pulse.
//
// Signals
//   req_valid    master -> slave  request present
//   req_ready    slave  -> master slave can accept a request this cycle
//   req_we       master -> slave  1 = store, 0 = load
//   req_size     master -> slave  00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned master -> slave  loads: 1 = zero-extend, 0 = sign-extend
//   req_addr     master -> slave  byte address
//   req_wdata    master -> slave  store data, right-justified
//   resp_valid   slave  -> master one-cycle completion pulse
//   resp_err     slave  -> master access error, valid with resp_valid
//   resp_rdata   slave  -> master load result
// -----------------------------------------------------------------------------
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// MEM-stage front end of DataMemory. Takes one load or store per request,
// converts the byte address to a word index, performs sub-word stores as
// read-modify-write, and extracts and extends sub-word loads. Misaligned,
// out-of-range and illegal-size accesses complete with resp_err and do not
// touch memory.
//
// Byte lanes are big-endian: offset k occupies bits [31-8k -: 8]. A half at
// offset 0 occupies [31:16], and a half at offset 2 occupies [15:0].
//
// Configuration macro: LSU_SUBWORD_EN
//   defined   - byte and half loads and stores are supported.
//   undefined - only word accesses are legal. Byte and half requests complete
//               with resp_err. The RMW states and lane logic are not built.
//
// Parameter
//   MEM_WORDS  DataMemory depth in 32-bit words; word index >= MEM_WORDS errors
//
// Ports
//   clk, rst_n  clock; asynchronous active-low reset
//   bus         request/response bundle (slave side)
//   mem_addr    word index to DataMemory = {2'b00, addr[31:2]}
//   mem_wdata   word to write
//   mem_write   DataMemory MemWrite
//   mem_read    DataMemory MemRead
//   mem_rdata   DataMemory ReadData, valid the cycle after mem_read
//   fsm_state   current FSM state, for observation only
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int MEM_WORDS = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    load_store_unit_if.slave         bus,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic                     mem_write,
    output logic                     mem_read,
    input  logic [31:0]              mem_rdata,
    output logic [2:0]               fsm_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD      = 3'd2,
        CAP     = 3'd3,
        RMW_RD  = 3'd4,
        RMW_MRG = 3'd5,
        RESP    = 3'd6
    } state_t;

    localparam logic [1:0]  SZ_BYTE     = 2'b00;
    localparam logic [1:0]  SZ_HALF     = 2'b01;
    localparam logic [1:0]  SZ_WORD     = 2'b10;
    localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

    state_t      state, state_d;
    logic        accept;
    logic        req_bad;
    logic [31:0] load_result;

    logic        mem_write_d, mem_read_d;
    logic [31:0] mem_addr_d, mem_wdata_d;
    logic        resp_valid_d, resp_err_d;
    logic [31:0] resp_rdata_d;

    assign accept        = bus.req_valid && (state == IDLE);
    assign bus.req_ready = (state == IDLE);
    assign fsm_state     = state;

    // Access legality, evaluated on the live request at the accept edge.
    always_comb begin
        req_bad = 1'b0;
        case (bus.req_size)
            SZ_WORD: req_bad = (bus.req_addr[1:0] != 2'b00);
`ifdef LSU_SUBWORD_EN
            SZ_HALF: req_bad = bus.req_addr[0];
            SZ_BYTE: req_bad = 1'b0;
`endif
            default: req_bad = 1'b1;
        endcase
        if (bus.req_addr[31:2] >= MEM_WORDS_W) begin
            req_bad = 1'b1;
        end
    end

`ifdef LSU_SUBWORD_EN
    // Request fields that later states need. Only the low half of the store
    // data is kept because word stores write req_wdata straight into mem_wdata.
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] merged;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q  <= SZ_WORD;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            wdata_q <= 16'h0000;
        end else if (accept) begin
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            off_q   <= bus.req_addr[1:0];
            wdata_q <= bus.req_wdata[15:0];
        end
    end

    // Lane extraction for loads and lane replacement for RMW stores.
    always_comb begin
        lane_b      = 8'h00;
        lane_h      = 16'h0000;
        load_result = mem_rdata;
        merged      = mem_rdata;
        case (off_q)
            2'd0:    lane_b = mem_rdata[31:24];
            2'd1:    lane_b = mem_rdata[23:16];
            2'd2:    lane_b = mem_rdata[15:8];
            default: lane_b = mem_rdata[7:0];
        endcase
        lane_h = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        case (size_q)
            SZ_BYTE: begin
                load_result = uns_q ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
                case (off_q)
                    2'd0:    merged[31:24] = wdata_q[7:0];
                    2'd1:    merged[23:16] = wdata_q[7:0];
                    2'd2:    merged[15:8]  = wdata_q[7:0];
                    default: merged[7:0]   = wdata_q[7:0];
                endcase
            end
            SZ_HALF: begin
                load_result = uns_q ? {16'h0000, lane_h} : {{16{lane_h[15]}}, lane_h};
                if (off_q[1]) merged[15:0]  = wdata_q;
                else          merged[31:16] = wdata_q;
            end
            default: begin
                load_result = mem_rdata;
                merged      = mem_rdata;
            end
        endcase
    end
`else
    // Word-only build: the extension control has no effect.
    logic unused_req_unsigned;
    assign unused_req_unsigned = bus.req_unsigned;
    assign load_result         = mem_rdata;
`endif

    // State register. All outputs are registered here too, loaded from the
    // values the output process derives for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            mem_addr       <= 32'h0;
            mem_wdata      <= 32'h0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'h0;
        end else begin
            state          <= state_d;
            mem_write      <= mem_write_d;
            mem_read       <= mem_read_d;
            mem_addr       <= mem_addr_d;
            mem_wdata      <= mem_wdata_d;
            bus.resp_valid <= resp_valid_d;
            bus.resp_err   <= resp_err_d;
            bus.resp_rdata <= resp_rdata_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_bad)                        state_d = RESP;
                    else if (!bus.req_we)               state_d = RD;
                    else if (bus.req_size == SZ_WORD)   state_d = WR;
                    else
`ifdef LSU_SUBWORD_EN
                                                        state_d = RMW_RD;
`else
                                                        state_d = WR;
`endif
                end
            end
            WR:      state_d = RESP;
            RD:      state_d = CAP;
            CAP:     state_d = RESP;
`ifdef LSU_SUBWORD_EN
            RMW_RD:  state_d = RMW_MRG;
            RMW_MRG: state_d = WR;
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: strobes follow the state being entered, so the registered
    // strobe is high for exactly the cycle spent in that state. mem_write and
    // mem_read depend on disjoint states and can never be high together.
    always_comb begin
        mem_write_d  = (state_d == WR);
`ifdef LSU_SUBWORD_EN
        mem_read_d   = (state_d == RD) || (state_d == RMW_RD);
`else
        mem_read_d   = (state_d == RD);
`endif
        resp_valid_d = (state_d == RESP);
        resp_err_d   = accept && req_bad;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        resp_rdata_d = bus.resp_rdata;

        if (accept && !req_bad) begin
            mem_addr_d = {2'b00, bus.req_addr[31:2]};
            if (bus.req_we && bus.req_size == SZ_WORD) begin
                mem_wdata_d = bus.req_wdata;
            end
        end
`ifdef LSU_SUBWORD_EN
        if (state == RMW_MRG) begin
            mem_wdata_d = merged;
        end
`endif
        // resp_rdata changes only on entry to RESP; it is zero unless the
        // response comes from a completed load.
        if (state_d == RESP && state != RESP) begin
            resp_rdata_d = (state == CAP) ? load_result : 32'h0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit with a behavioural DataMemory model.
// A vector table covers stores, loads, extension and error cases; the reset
// tests are hand-written sequences. Sub-word vectors follow LSU_SUBWORD_EN.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;
    logic [2:0]  fsm_state;

    logic [31:0] mem_model [0:31];
    logic [31:0] exp_q [$];
    vec_t        vecs [$];

    int n_checks;
    int n_pass;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_WORDS(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_rdata (mem_rdata),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMemory: synchronous read, data valid the cycle after mem_read.
    always @(posedge clk) begin
        if (mem_read)  mem_rdata <= mem_model[mem_addr[4:0]];
        if (mem_write) mem_model[mem_addr[4:0]] <= mem_wdata;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic err, input logic [31:0] rdata);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    function automatic int exp_lat(input vec_t v);
        if (v.err)                 return 1;
        if (!v.we)                 return 3;
        if (v.size == 2'b10)       return 2;
        return 4;
    endfunction

    task automatic drive_req(input vec_t v);
        bus.req_valid    = 1'b1;
        bus.req_we       = v.we;
        bus.req_size     = v.size;
        bus.req_unsigned = v.uns;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wdata;
    endtask

    // Request fields change after accept; the DUT must ignore them.
    task automatic scramble_req();
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'($urandom_range(0, 1));
        bus.req_size     = 2'($urandom_range(0, 3));
        bus.req_unsigned = 1'($urandom_range(0, 1));
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
    endtask

    // Called #1 after a posedge; returns #1 after a posedge.
    task automatic run_vec(input int idx, input vec_t v);
        int n;
        int lat;
        int nrd;
        int nwr;
        int enrd;
        int enwr;
        logic [31:0] exp_r;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk($sformatf("v%0d ready_wait", idx), {31'b0, bus.req_ready}, 32'd1);
        drive_req(v);
        @(posedge clk); #1;
        exp_q.push_back(v.rdata);
        scramble_req();
        lat = 1; nrd = 0; nwr = 0;
        while (bus.resp_valid !== 1'b1 && lat < 12) begin
            if (mem_read)  nrd++;
            if (mem_write) nwr++;
            if (mem_read || mem_write)
                chk($sformatf("v%0d mem_addr", idx), mem_addr, {2'b00, v.addr[31:2]});
            if (mem_write)
                chk($sformatf("v%0d rw_overlap", idx), {31'b0, mem_read}, 32'd0);
            chk($sformatf("v%0d ready_busy", idx), {31'b0, bus.req_ready}, 32'd0);
            @(posedge clk); #1; lat++;
        end
        enrd = (!v.err && (!v.we || v.size != 2'b10)) ? 1 : 0;
        enwr = (!v.err && v.we) ? 1 : 0;
        exp_r = exp_q.pop_front();
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(exp_lat(v)));
        chk($sformatf("v%0d resp_err", idx), {31'b0, bus.resp_err}, {31'b0, v.err});
        chk($sformatf("v%0d resp_rdata", idx), bus.resp_rdata, exp_r);
        chk($sformatf("v%0d n_read", idx), 32'(nrd), 32'(enrd));
        chk($sformatf("v%0d n_write", idx), 32'(nwr), 32'(enwr));
        @(posedge clk); #1;
        chk($sformatf("v%0d resp_pulse", idx), {31'b0, bus.resp_valid}, 32'd0);
        chk($sformatf("v%0d ready_after", idx), {31'b0, bus.req_ready}, 32'd1);
        chk($sformatf("v%0d rdata_hold", idx), bus.resp_rdata, exp_r);
    endtask

    // Reset held for a few cycles must keep the bus idle with req_ready=1.
    task automatic hold_reset(input string tag);
        chk({tag, " mem_write_async"}, {31'b0, mem_write}, 32'd0);
        chk({tag, " ready_in_rst"}, {31'b0, bus.req_ready}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk({tag, " mem_write_rst"}, {31'b0, mem_write}, 32'd0);
            chk({tag, " resp_valid_rst"}, {31'b0, bus.resp_valid}, 32'd0);
            chk({tag, " ready_rst"}, {31'b0, bus.req_ready}, 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- test ----------------
    initial begin
        logic [31:0] exp_w10;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

        // Vector table: we, size, unsigned, addr, wdata, err, rdata
        vecs.push_back(mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF));
        vecs.push_back(mk(1, 2'b10, 0, 32'h20, 32'h80FF7F01, 0, 32'h0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0,        0, 32'h80FF7F01));
        vecs.push_back(mk(1, 2'b10, 0, 32'h7C, 32'h12345678, 0, 32'h0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h7C, 32'h0,        0, 32'h12345678));
        vecs.push_back(mk(0, 2'b10, 0, 32'h12, 32'h0,        1, 32'h0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h13, 32'hFFFF,     1, 32'h0));
        vecs.push_back(mk(0, 2'b11, 0, 32'h10, 32'h0,        1, 32'h0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h80, 32'h0,        1, 32'h0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h80, 32'h55555555, 1, 32'h0));
`ifdef LSU_SUBWORD_EN
        vecs.push_back(mk(1, 2'b10, 0, 32'h10, 32'h11223344, 0, 32'h0));
        vecs.push_back(mk(1, 2'b00, 0, 32'h11, 32'hFFFFFFAA, 0, 32'h0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        0, 32'h11AA3344));
        vecs.push_back(mk(0, 2'b00, 0, 32'h20, 32'h0,        0, 32'hFFFFFF80));
        vecs.push_back(mk(0, 2'b00, 1, 32'h20, 32'h0,        0, 32'h00000080));
        vecs.push_back(mk(0, 2'b01, 0, 32'h22, 32'h0,        0, 32'h00007F01));
        vecs.push_back(mk(0, 2'b01, 1, 32'h20, 32'h0,        0, 32'h000080FF));
        vecs.push_back(mk(0, 2'b00, 0, 32'h23, 32'h0,        0, 32'h00000001));
        vecs.push_back(mk(1, 2'b01, 0, 32'h12, 32'h0000BEEF, 0, 32'h0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        0, 32'h11AABEEF));
        exp_w10 = 32'h11AABEEF;
`else
        vecs.push_back(mk(0, 2'b00, 0, 32'h20, 32'h0,        1, 32'h0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h20, 32'h0,        1, 32'h0));
        vecs.push_back(mk(1, 2'b00, 0, 32'h11, 32'hAA,       1, 32'h0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h22, 32'h0,        1, 32'h0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0,        0, 32'h80FF7F01));
        exp_w10 = 32'hDEADBEEF;
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst req_ready",  {31'b0, bus.req_ready},  32'd1);
        chk("rst resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst resp_err",   {31'b0, bus.resp_err},   32'd0);
        chk("rst mem_write",  {31'b0, mem_write},      32'd0);
        chk("rst mem_read",   {31'b0, mem_read},       32'd0);
        chk("rst resp_rdata", bus.resp_rdata,          32'h0);
        chk("rst mem_addr",   mem_addr,                32'h0);
        chk("rst mem_wdata",  mem_wdata,               32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset while a word store sits in WR: the write must not happen.
        drive_req(mk(1, 2'b10, 0, 32'h10, 32'hCAFEF00D, 0, 32'h0));
        @(posedge clk); #1;
        scramble_req();
        chk("wr_rst mem_write_set", {31'b0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        hold_reset("wr_rst");
        run_vec(100, mk(0, 2'b10, 0, 32'h10, 32'h0, 0, exp_w10));

`ifdef LSU_SUBWORD_EN
        // Reset during RMW_MRG of a byte store: memory keeps its old word.
        drive_req(mk(1, 2'b00, 0, 32'h10, 32'h00000055, 0, 32'h0));
        @(posedge clk); #1;
        scramble_req();
        chk("rmw_rst mem_read_set", {31'b0, mem_read}, 32'd1);
        @(posedge clk); #1;
        chk("rmw_rst state_mrg", {29'b0, fsm_state}, 32'd5);
        rst_n = 1'b0;
        #1;
        hold_reset("rmw_rst");
        run_vec(101, mk(0, 2'b10, 0, 32'h10, 32'h0, 0, exp_w10));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
